// File: rtl/drap_pkg.sv
// Shared widths and loader state encoding for the DRAP instruction-memory controller.
package drap_pkg;

    localparam int DRAP_B = 32;
    localparam int DRAP_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ld_state_t;

endpackage

// File: rtl/drap_ld_counter.sv
// Loader write pointer and words-remaining counter with wrap and count saturation.
// Latency: ptr/remaining update on the edge after load or dec.
// Backpressure: none; dec is asserted only on accepted transfers.
module drap_ld_counter #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] base,
    input  logic [W:0]   count,
    input  logic         dec,
    output logic [W-1:0] ptr,
    output logic         last
);

    // A burst can never cover more than the whole memory, so every word is written at most once.
    localparam logic [W:0] FULL = {1'b1, {W{1'b0}}};

    logic [W:0] remaining;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            remaining <= '0;
        end else if (load) begin
            ptr       <= base;
            remaining <= (count > FULL) ? FULL : count;
        end else if (dec) begin
            ptr       <= ptr + 1'b1;
            remaining <= remaining - 1'b1;
        end
    end

    assign last = (remaining == {{W{1'b0}}, 1'b1});

endmodule

// File: rtl/drap_imem_loader_arb.sv
// Arbitrates the single IMEM port between CPU fetch and a burst program loader.
// Latency: fetch data is registered (1 cycle); loader writes land on the accepting edge.
// Backpressure: loader owns the port while busy and stalls the CPU; ld_ready drops on abort.
module drap_imem_loader_arb
    import drap_pkg::*;
#(
    parameter int B = DRAP_B,
    parameter int W = DRAP_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         fetch_req,
    input  logic [W-1:0] fetch_addr,
    output logic [B-1:0] fetch_data,
    output logic         fetch_valid,
    output logic         cpu_stall,
    input  logic         ld_start,
    input  logic [W-1:0] ld_base,
    input  logic [W:0]   ld_count,
    input  logic         ld_valid,
    input  logic [B-1:0] ld_data,
    output logic         ld_ready,
    input  logic         ld_abort,
    output logic         ld_busy,
    output logic         ld_done,
    output logic [W-1:0] mem_addr,
    output logic [B-1:0] mem_wdata,
    output logic         mem_write,
    input  logic [B-1:0] mem_rdata
);

    ld_state_t    state, state_nxt;
    logic [W-1:0] ptr;
    logic         last;
    logic         in_load;
    logic         xfer;
    logic         start_load;
    logic         fetch_grant;

    assign in_load     = (state == LOAD);
    assign ld_ready    = in_load && !ld_abort;
    assign xfer        = ld_ready && ld_valid;
    assign start_load  = (state == IDLE) && ld_start && (ld_count != '0);
    assign fetch_grant = fetch_req && (state == IDLE);

    drap_ld_counter #(.W(W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_load),
        .base  (ld_base),
        .count (ld_count),
        .dec   (xfer),
        .ptr   (ptr),
        .last  (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ld_start) begin
                    state_nxt = (ld_count != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                if (ld_abort) begin
                    state_nxt = IDLE;
                end else if (xfer && last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Fetch is only granted in IDLE, so a read never overlaps a loader write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid <= 1'b0;
            fetch_data  <= '0;
        end else begin
            fetch_valid <= fetch_grant;
            if (fetch_grant) begin
                fetch_data <= mem_rdata;
            end
        end
    end

    assign cpu_stall = (state != IDLE);
    assign ld_busy   = (state != IDLE);
    assign ld_done   = (state == DONE);
    assign mem_addr  = in_load ? ptr : fetch_addr;
    assign mem_wdata = ld_data;
    assign mem_write = xfer;

endmodule

// File: tb/tb_drap_imem_loader_arb.sv
// Directed bench for drap_imem_loader_arb with a burst-level reference model and a memory array.
module tb_drap_imem_loader_arb;

    localparam int B = 32;
    localparam int W = 7;
    localparam int N = 128;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         fetch_req = 1'b0;
    logic [W-1:0] fetch_addr = '0;
    logic [B-1:0] fetch_data;
    logic         fetch_valid;
    logic         cpu_stall;
    logic         ld_start = 1'b0;
    logic [W-1:0] ld_base = '0;
    logic [W:0]   ld_count = '0;
    logic         ld_valid = 1'b0;
    logic [B-1:0] ld_data = '0;
    logic         ld_ready;
    logic         ld_abort = 1'b0;
    logic         ld_busy;
    logic         ld_done;
    logic [W-1:0] mem_addr;
    logic [B-1:0] mem_wdata;
    logic         mem_write;
    logic [B-1:0] mem_rdata;

    logic [B-1:0] mem    [N];
    logic [B-1:0] shadow [N];

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int stall_cnt = 0;

    // Reference model state: 0 idle, 1 loading, 2 done pulse.
    int           m_phase = 0;
    int           m_next = 0;
    int           m_left = 0;
    logic         m_fv = 1'b0;
    logic [B-1:0] m_fd = '0;

    drap_imem_loader_arb #(.B(B), .W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_data  (fetch_data),
        .fetch_valid (fetch_valid),
        .cpu_stall   (cpu_stall),
        .ld_start    (ld_start),
        .ld_base     (ld_base),
        .ld_count    (ld_count),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .ld_abort    (ld_abort),
        .ld_busy     (ld_busy),
        .ld_done     (ld_done),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_write   (mem_write),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory: write intent is captured mid-cycle and committed on the next edge.
    initial begin
        logic         w_en;
        logic [W-1:0] w_addr;
        logic [B-1:0] w_data;
        for (int i = 0; i < N; i++) begin
            mem[i]    = 32'h1000_0000 + 32'(i);
            shadow[i] = 32'h1000_0000 + 32'(i);
        end
        mem[5]    = 32'hDEAD_BEEF;
        shadow[5] = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            w_en   = mem_write;
            w_addr = mem_addr;
            w_data = mem_wdata;
            @(posedge clk);
            if (w_en && rst_n) mem[w_addr] = w_data;
        end
    end

    // Reference model of the burst protocol.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_phase = 0;
                m_next  = 0;
                m_left  = 0;
                m_fv    = 1'b0;
                m_fd    = '0;
            end else begin
                m_fv = fetch_req && (m_phase == 0);
                if (m_fv) m_fd = shadow[fetch_addr];
                if (m_phase == 0) begin
                    if (ld_start) begin
                        if (ld_count == 0) begin
                            m_phase = 2;
                        end else begin
                            m_phase = 1;
                            m_next  = int'(ld_base);
                            m_left  = (int'(ld_count) > N) ? N : int'(ld_count);
                        end
                    end
                end else if (m_phase == 1) begin
                    if (ld_abort) begin
                        m_phase = 0;
                    end else if (ld_valid) begin
                        shadow[m_next] = ld_data;
                        m_next = (m_next + 1) % N;
                        m_left = m_left - 1;
                        if (m_left == 0) m_phase = 2;
                    end
                end else begin
                    m_phase = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    initial begin
        logic exp_busy, exp_ready, exp_write;
        logic [W-1:0] exp_addr;
        forever begin
            @(negedge clk);
            exp_busy  = (m_phase != 0);
            exp_ready = (m_phase == 1) && !ld_abort;
            exp_write = exp_ready && ld_valid;
            exp_addr  = (m_phase == 1) ? 7'(m_next) : fetch_addr;
            chk("cyc_stall", 32'(cpu_stall), 32'(exp_busy));
            chk("cyc_busy", 32'(ld_busy), 32'(exp_busy));
            chk("cyc_ready", 32'(ld_ready), 32'(exp_ready));
            chk("cyc_write", 32'(mem_write), 32'(exp_write));
            chk("cyc_addr", 32'(mem_addr), 32'(exp_addr));
            if (exp_write) chk("cyc_wdata", mem_wdata, ld_data);
            chk("cyc_done", 32'(ld_done), 32'(m_phase == 2));
            chk("cyc_fvalid", 32'(fetch_valid), 32'(m_fv));
            chk("cyc_fdata", fetch_data, m_fd);
            if (mem_write) wr_cnt++;
            if (ld_done) done_cnt++;
            if (cpu_stall) stall_cnt++;
        end
    end

    task automatic start(input int base, input int count);
        ld_start = 1'b1;
        ld_base  = 7'(base);
        ld_count = 8'(count);
        tick();
        ld_start = 1'b0;
    endtask

    task automatic fetch(input int addr, input logic [31:0] exp, input string nm);
        fetch_req  = 1'b1;
        fetch_addr = 7'(addr);
        tick();
        fetch_req = 1'b0;
        chk({nm, "_valid"}, 32'(fetch_valid), 32'd1);
        chk({nm, "_data"}, fetch_data, exp);
    endtask

    initial begin
        int mism;
        #1;
        chk("rst_fvalid", 32'(fetch_valid), 32'd0);
        chk("rst_fdata", fetch_data, 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_done", 32'(ld_done), 32'd0);
        chk("rst_write", 32'(mem_write), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Fetch only.
        fetch(5, 32'hDEAD_BEEF, "fetch5");
        chk("fetch5_stall", 32'(cpu_stall), 32'd0);

        // Normal burst of three.
        stall_cnt = 0;
        done_cnt  = 0;
        start(10, 3);
        ld_valid = 1'b1;
        ld_data = 32'hAAAA_0001; tick();
        ld_data = 32'hAAAA_0002; tick();
        ld_data = 32'hAAAA_0003; tick();
        ld_valid = 1'b0;
        chk("burst_done_hi", 32'(ld_done), 32'd1);
        tick();
        chk("burst_done_lo", 32'(ld_done), 32'd0);
        chk("burst_stall_cycles", 32'(stall_cnt), 32'd4);
        chk("burst_done_pulses", 32'(done_cnt), 32'd1);
        fetch(10, 32'hAAAA_0001, "rd10");
        fetch(11, 32'hAAAA_0002, "rd11");
        fetch(12, 32'hAAAA_0003, "rd12");

        // Wrap with backpressure.
        wr_cnt = 0;
        start(126, 4);
        for (int i = 0; i < 6; i++) begin
            logic [5:0] pat;
            pat = 6'b110101;
            ld_valid = pat[i];
            ld_data  = 32'hC000_0000 + 32'(i);
            #1;
            chk("wrap_ready", 32'(ld_ready), 32'd1);
            tick();
        end
        ld_valid = 1'b0;
        chk("wrap_done", 32'(ld_done), 32'd1);
        tick();
        chk("wrap_writes", 32'(wr_cnt), 32'd4);
        chk("wrap_m126", mem[126], 32'hC000_0000);
        chk("wrap_m127", mem[127], 32'hC000_0002);
        chk("wrap_m0", mem[0], 32'hC000_0004);
        chk("wrap_m1", mem[1], 32'hC000_0005);

        // Abort on the third word.
        done_cnt = 0;
        start(20, 5);
        ld_valid = 1'b1;
        ld_data = 32'hE000_0000; tick();
        ld_data = 32'hE000_0001; tick();
        ld_data = 32'hE000_0002;
        ld_abort = 1'b1;
        #1;
        chk("abort_write", 32'(mem_write), 32'd0);
        chk("abort_ready", 32'(ld_ready), 32'd0);
        tick();
        ld_abort = 1'b0;
        ld_valid = 1'b0;
        chk("abort_idle", 32'(ld_busy), 32'd0);
        tick();
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_m20", mem[20], 32'hE000_0000);
        chk("abort_m21", mem[21], 32'hE000_0001);
        chk("abort_m22", mem[22], 32'h1000_0016);

        // Zero-length burst.
        wr_cnt = 0;
        done_cnt = 0;
        start(30, 0);
        chk("zero_done", 32'(ld_done), 32'd1);
        tick();
        chk("zero_idle", 32'(ld_busy), 32'd0);
        chk("zero_writes", 32'(wr_cnt), 32'd0);
        chk("zero_pulses", 32'(done_cnt), 32'd1);

        // Oversize count saturates to the memory size.
        wr_cnt = 0;
        start(0, 200);
        ld_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            ld_data = 32'hA000_0000 + 32'(i);
            tick();
        end
        ld_valid = 1'b0;
        chk("big_done", 32'(ld_done), 32'd1);
        tick();
        chk("big_writes", 32'(wr_cnt), 32'd128);
        chk("big_m0", mem[0], 32'hA000_0000);
        chk("big_m127", mem[127], 32'hA000_007F);

        // Reset in the middle of a six-word burst.
        start(40, 6);
        ld_valid = 1'b1;
        ld_data = 32'hF000_0000; tick();
        ld_data = 32'hF000_0001; tick();
        ld_data = 32'hF000_0002;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_write", 32'(mem_write), 32'd0);
        chk("rstmid_stall", 32'(cpu_stall), 32'd0);
        chk("rstmid_ready", 32'(ld_ready), 32'd0);
        chk("rstmid_done", 32'(ld_done), 32'd0);
        chk("rstmid_fvalid", 32'(fetch_valid), 32'd0);
        ld_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        start(50, 1);
        chk("restart_busy", 32'(cpu_stall), 32'd1);
        ld_valid = 1'b1;
        ld_data  = 32'h5A5A_5A5A;
        tick();
        ld_valid = 1'b0;
        chk("restart_done", 32'(ld_done), 32'd1);
        tick();
        chk("rstmid_m40", mem[40], 32'hF000_0000);
        chk("rstmid_m41", mem[41], 32'hF000_0001);
        chk("rstmid_m42", mem[42], 32'hA000_002A);
        chk("restart_m50", mem[50], 32'h5A5A_5A5A);

        mism = 0;
        for (int i = 0; i < N; i++) begin
            if (mem[i] !== shadow[i]) mism++;
        end
        chk("mem_vs_model", 32'(mism), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
